mem_stream_reader: RTL

- Read-side master for the team's synchronous single-clock memories: one write port, plus a registered read port with 1-cycle read latency.
- On START it sweeps iLen consecutive words from iBase. It drives READ/oRDAddr into the memory and captures the memory's registered Q.
- It presents the words as a valid/ready stream, with a 2-entry skid buffer so downstream backpressure never loses data.
- It sits between a memory instance and any stream consumer (DMA out, serializer, checker).

---
 rtl/mem_stream_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// Sweeps a block of words out of a registered-read memory and presents them on a
// valid/ready stream through a 2-entry skid buffer.
module mem_stream_reader #(
  parameter int WIDTH  = 8,
  parameter int SIZE_E = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [SIZE_E-1:0] iBase,
  input  logic [SIZE_E:0]   iLen,
  output logic              BUSY,
  output logic              DONE,
  output logic              READ,
  output logic [SIZE_E-1:0] oRDAddr,
  input  logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  oData,
  output logic              oValid,
  input  logic              iReady
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SIZE_E-1:0] ADDR_ONE = 1;
  localparam logic [SIZE_E:0]   LEN_ONE  = 1;

  logic [1:0]              state_q, state_d;
  logic [SIZE_E-1:0]       addr_q, addr_d;
  logic [SIZE_E-1:0]       last_q, last_d;
  logic [SIZE_E:0]         rem_q, rem_d;
  logic [SIZE_E:0]         left_q, left_d;
  logic                    infl_q, infl_d;
  logic [1:0][WIDTH-1:0]   buf_q, buf_d;
  logic                    head_q, head_d;
  logic                    tail_q, tail_d;
  logic [1:0]              occ_q, occ_d;

  logic       pop, push, rd;
  logic [1:0] room;

  always_comb begin
    pop  = (occ_q != 2'd0) && iReady;
    push = infl_q;
    // Slots committed once this cycle's pop leaves: stored words plus the word returning now.
    // A new read is safe only if that leaves one slot for it to land in next cycle.
    room = occ_q - {1'b0, pop} + {1'b0, infl_q};
    rd   = (state_q == S_RUN) && (rem_q != '0) && (room < 2'd2);

    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    rem_d   = rem_q;
    left_d  = left_q;
    infl_d  = rd;
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = iBase;
          rem_d   = iLen;
          left_d  = iLen;
          state_d = (iLen != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (rd) begin
          last_d = addr_q;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
        end
        if (pop) begin
          left_d = left_q - LEN_ONE;
          if (left_q == LEN_ONE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      buf_d[tail_q] = Q;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      left_q  <= '0;
      infl_q  <= 1'b0;
      buf_q   <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      infl_q  <= infl_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  // The strobe reacts to same-cycle iReady so a 2-entry buffer sustains one word per cycle.
  assign READ    = rd;
  assign oRDAddr = rd ? addr_q : last_q;
  assign oData   = buf_q[head_q];
  assign oValid  = (occ_q != 2'd0);
  assign BUSY    = (state_q == S_RUN);
  assign DONE    = (state_q == S_DONE);

endmodule
